// File: rtl/filter_pkg.sv
// Shared types and constants for the 5x5 filter line-buffer controller.
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int LN_NUM = 4;
  localparam logic [LN_NUM-1:0] WEN_INIT = 4'b0001;

  function automatic logic [LN_NUM-1:0] rotl_wen(input logic [LN_NUM-1:0] ptr);
    return {ptr[LN_NUM-2:0], ptr[LN_NUM-1]};
  endfunction

endpackage

// File: rtl/filter_sync_delay.sv
// Fixed-latency delay of the {vs, hs, de} sync bundle, aligning it with the window pipeline.
module filter_sync_delay #(
  parameter int PIPE_LAT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] sync,
  output logic [2:0] sync_dly
);

  logic [2:0] pipe [PIPE_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= sync;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign sync_dly = pipe[PIPE_LAT-1];

endmodule

// File: rtl/filter_line_ctrl_5x5.sv
// Line-buffer write/read sequencing and window-valid control for a 5x5 filter.
// Border masking is compiled in when FILTER_BORDER_MASK_EN is defined.
//   state | meaning
//   IDLE  | no frame seen since reset, pixel activity ignored
//   FILL  | first four lines of a frame being written, no window yet
//   RUN   | line buffers primed, convolution enabled on active pixels
module filter_line_ctrl_5x5 #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WIDTH  = 1920,
  parameter int PIPE_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_vs,
  input  logic                  i_hs,
  input  logic                  i_de,
  input  logic                  i_bypass,
  output logic [3:0]            o_mem_wen,
  output logic                  o_mem_ren,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [1:0]            o_conv_ln_sel,
  output logic                  o_conv_en,
  output logic                  o_bypass,
  output logic                  o_border,
  output logic                  o_err,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de
);
  import filter_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MAX_WIDTH - 1);

  state_t state, state_nxt;
  logic vs_q, de_q;
  logic vs_rise, de_rise, de_fall, active, line_end, ovf, border;
  logic [2:0] line_cnt;
  logic [LN_NUM-1:0] wen_ptr;
  logic [1:0] ln_sel;
  logic [ADDR_WIDTH-1:0] addr_q, addr_cur;
  logic full_q, err_q, byp_q;
  logic [2:0] sync_dly;

  assign vs_rise  = i_vs & ~vs_q;
  assign de_rise  = i_de & ~de_q;
  assign de_fall  = ~i_de & de_q;
  assign active   = (state != IDLE);
  // A frame restart on the same cycle as a line end wins; the rotation is dropped.
  assign line_end = active & de_fall & ~vs_rise;
  assign addr_cur = (!active || de_rise) ? '0 : addr_q;
  // full_q marks that the last legal address was already written this line.
  assign ovf      = active & i_de & ~de_rise & full_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_mem_ren = 1'b0;
    o_mem_wen = '0;
    o_conv_en = 1'b0;
    if (vs_rise) begin
      state_nxt = FILL;
    end else if (state == FILL && line_end && line_cnt == 3'd3) begin
      state_nxt = RUN;
    end
    if (active && i_de) begin
      o_mem_ren = 1'b1;
      if (!ovf) o_mem_wen = wen_ptr;
    end
    if (state == RUN && i_de && !byp_q && !border) o_conv_en = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q     <= 1'b0;
      de_q     <= 1'b0;
      line_cnt <= '0;
      wen_ptr  <= WEN_INIT;
      ln_sel   <= '0;
      addr_q   <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      byp_q    <= 1'b0;
    end else begin
      vs_q <= i_vs;
      de_q <= i_de;
      if (vs_rise) begin
        line_cnt <= '0;
        wen_ptr  <= WEN_INIT;
        ln_sel   <= '0;
        addr_q   <= '0;
        full_q   <= 1'b0;
        err_q    <= 1'b0;
        byp_q    <= i_bypass;
      end else if (active) begin
        if (i_de) begin
          addr_q <= (addr_cur == ADDR_LAST) ? ADDR_LAST : addr_cur + ADDR_WIDTH'(1);
          full_q <= (addr_cur == ADDR_LAST);
          if (ovf) err_q <= 1'b1;
        end
        if (line_end) begin
          wen_ptr <= rotl_wen(wen_ptr);
          ln_sel  <= ln_sel + 2'd1;
          if (line_cnt != 3'd4) line_cnt <= line_cnt + 3'd1;
        end
      end
    end
  end

`ifdef FILTER_BORDER_MASK_EN
  logic [ADDR_WIDTH:0] width_q;
  logic [1:0]          run_lines;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      width_q   <= '0;
      run_lines <= '0;
    end else if (vs_rise) begin
      run_lines <= '0;
    end else if (line_end) begin
      width_q <= full_q ? (ADDR_WIDTH+1)'(MAX_WIDTH) : {1'b0, addr_q};
      if (state == RUN && run_lines != 2'd2) run_lines <= run_lines + 2'd1;
    end
  end

  // Edges are judged against the width of the previous line.
  assign border = i_de && (state == RUN) &&
                  (run_lines != 2'd2 || addr_cur < ADDR_WIDTH'(2) ||
                   ({1'b0, addr_cur} + (ADDR_WIDTH+1)'(2)) >= width_q);
`else
  assign border = 1'b0;
`endif

  assign o_mem_addr    = addr_cur;
  assign o_conv_ln_sel = ln_sel;
  assign o_bypass      = byp_q;
  assign o_border      = border;
  assign o_err         = err_q;

  filter_sync_delay #(
    .PIPE_LAT(PIPE_LAT)
  ) u_sync_delay (
    .clk     (clk),
    .rstn    (rstn),
    .sync    ({i_vs, i_hs, i_de}),
    .sync_dly(sync_dly)
  );

  assign {o_vs, o_hs, o_de} = sync_dly;

endmodule

// File: tb/tb_filter_line_ctrl_5x5.sv
// Self-checking bench for filter_line_ctrl_5x5: per-cycle pixel-level model plus literal checks.
module tb_filter_line_ctrl_5x5;

  localparam int AW   = 12;
  localparam int MAXW = 16;
  localparam int LAT  = 4;
`ifdef FILTER_BORDER_MASK_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0, i_bypass = 1'b0;
  logic [3:0]    o_mem_wen;
  logic          o_mem_ren;
  logic [AW-1:0] o_mem_addr;
  logic [1:0]    o_conv_ln_sel;
  logic o_conv_en, o_bypass, o_border, o_err, o_vs, o_hs, o_de;

  int errors = 0;
  int checks = 0;

  filter_line_ctrl_5x5 #(
    .ADDR_WIDTH(AW),
    .MAX_WIDTH (MAXW),
    .PIPE_LAT  (LAT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_vs         (i_vs),
    .i_hs         (i_hs),
    .i_de         (i_de),
    .i_bypass     (i_bypass),
    .o_mem_wen    (o_mem_wen),
    .o_mem_ren    (o_mem_ren),
    .o_mem_addr   (o_mem_addr),
    .o_conv_ln_sel(o_conv_ln_sel),
    .o_conv_en    (o_conv_en),
    .o_bypass     (o_bypass),
    .o_border     (o_border),
    .o_err        (o_err),
    .o_vs         (o_vs),
    .o_hs         (o_hs),
    .o_de         (o_de)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state in frame/line/pixel terms: lines finished in this frame,
  // de-high cycles so far in the current line, input history for the delay.
  bit m_active, m_prev_de, m_prev_vs, m_byp, m_err;
  int m_lines, m_pix, m_prev_width;
  logic [2:0] hq[$];

  function automatic int e_pix();
    return (i_de && !m_prev_de) ? 0 : m_pix;
  endfunction

  function automatic logic [31:0] e_addr();
    if (!m_active) return 0;
    return (e_pix() > MAXW - 1) ? MAXW - 1 : e_pix();
  endfunction

  function automatic logic [3:0] e_wen();
    if (m_active && i_de && e_pix() < MAXW) return 4'(1 << (m_lines % 4));
    return 4'd0;
  endfunction

  function automatic logic e_run();
    return m_active && m_lines >= 4;
  endfunction

  function automatic logic e_border();
    if (!BORDER) return 1'b0;
    return i_de && e_run() &&
           (m_lines < 6 || e_addr() < 2 || int'(e_addr()) + 2 >= m_prev_width);
  endfunction

  function automatic logic [2:0] e_dly();
    if (hq.size() >= LAT) return hq[hq.size() - LAT];
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_active     <= 1'b0;
      m_prev_de    <= 1'b0;
      m_prev_vs    <= 1'b0;
      m_byp        <= 1'b0;
      m_err        <= 1'b0;
      m_lines      <= 0;
      m_pix        <= 0;
      m_prev_width <= 0;
      hq.delete();
    end else begin
      hq.push_back({i_vs, i_hs, i_de});
      m_prev_de <= i_de;
      m_prev_vs <= i_vs;
      if (i_vs && !m_prev_vs) begin
        m_active <= 1'b1;
        m_lines  <= 0;
        m_err    <= 1'b0;
        m_byp    <= i_bypass;
        m_pix    <= 0;
      end else if (m_active) begin
        if (i_de) begin
          m_pix <= e_pix() + 1;
          if (e_pix() >= MAXW) m_err <= 1'b1;
        end
        if (!i_de && m_prev_de) begin
          m_prev_width <= (m_pix > MAXW) ? MAXW : m_pix;
          m_lines      <= m_lines + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("reset_outputs", {o_mem_wen, o_mem_ren, o_mem_addr, o_conv_ln_sel, o_conv_en,
                            o_bypass, o_border, o_err, o_vs, o_hs, o_de}, 32'd0);
    end else begin
      chk("wen", o_mem_wen, e_wen());
      chk("ren", o_mem_ren, m_active && i_de);
      chk("addr", o_mem_addr, e_addr());
      chk("ln_sel", o_conv_ln_sel, m_lines % 4);
      chk("conv_en", o_conv_en, i_de && e_run() && !m_byp && !e_border());
      chk("border", o_border, e_border());
      chk("bypass", o_bypass, m_byp);
      chk("err", o_err, m_err);
      chk("sync_dly", {o_vs, o_hs, o_de}, e_dly());
    end
  end

  task automatic tick(input logic vs, input logic hs, input logic de, input logic byp);
    @(posedge clk);
    #1;
    i_vs = vs; i_hs = hs; i_de = de; i_bypass = byp;
  endtask

  task automatic frame_start(input logic byp);
    tick(1'b1, 1'b0, 1'b0, byp);
    tick(1'b1, 1'b0, 1'b0, byp);
    tick(1'b0, 1'b0, 1'b0, byp);
  endtask

  task automatic line(input int n, input logic byp, output logic [3:0] fw,
                      output logic [31:0] wb, output logic [31:0] cb,
                      output logic [31:0] bb, output logic [AW-1:0] la);
    fw = '0; wb = '0; cb = '0; bb = '0; la = '0;
    tick(1'b0, 1'b1, 1'b0, byp);
    repeat (5) tick(1'b0, 1'b0, 1'b0, byp);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b1, byp);
      @(negedge clk);
      if (i == 0) fw = o_mem_wen;
      wb[i] = |o_mem_wen;
      cb[i] = o_conv_en;
      bb[i] = o_border;
      la    = o_mem_addr;
    end
    tick(1'b0, 1'b0, 1'b0, byp);
    tick(1'b0, 1'b0, 1'b0, byp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0]    fw;
    logic [31:0]   wb, cb, bb, cb_any;
    logic [AW-1:0] la;
    logic [6:0]    hs_bits;
    logic [3:0]    gap;
    logic [3:0]    exp_fw [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_addr", o_mem_addr, 0);

    // Pixel activity before any vsync is ignored.
    line(8, 1'b0, fw, wb, cb, bb, la);
    chk("idle_wen", wb, 32'd0);
    chk("idle_addr", la, 0);

    // Seven 8-pixel lines: four fill lines then the window runs.
    frame_start(1'b0);
    for (int ln = 0; ln < 7; ln++) begin
      line(8, 1'b0, fw, wb, cb, bb, la);
      chk($sformatf("frameA_wen_l%0d", ln + 1), fw, exp_fw[ln]);
      if (ln < 4)
        chk($sformatf("frameA_conv_l%0d", ln + 1), cb, 32'd0);
      else if (ln < 6)
        chk($sformatf("frameA_conv_l%0d", ln + 1), cb, BORDER ? 32'h00 : 32'hFF);
      else begin
        chk("frameA_conv_l7", cb, BORDER ? 32'h3C : 32'hFF);
        chk("frameA_border_l7", bb, BORDER ? 32'hC3 : 32'h00);
      end
    end

    // Single-cycle hsync appears at the output LAT cycles later, one cycle wide.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    hs_bits[0] = o_hs;
    for (int k = 1; k < 7; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      hs_bits[k] = o_hs;
    end
    chk("hs_delay", hs_bits, 7'b0010000);

    // Bypass sampled at vsync holds for the whole frame.
    frame_start(1'b1);
    cb_any = '0;
    for (int ln = 0; ln < 6; ln++) begin
      line(8, (ln < 3), fw, wb, cb, bb, la);
      cb_any |= cb;
    end
    chk("bypass_conv", cb_any, 32'd0);
    @(negedge clk);
    chk("bypass_held", o_bypass, 1'b1);

    // Overlong line: address saturates and writes stop.
    frame_start(1'b0);
    line(20, 1'b0, fw, wb, cb, bb, la);
    chk("ovf_wen_bits", wb, 32'h0000FFFF);
    chk("ovf_addr", la, MAXW - 1);
    @(negedge clk);
    chk("ovf_err", o_err, 1'b1);
    frame_start(1'b0);
    @(negedge clk);
    chk("err_cleared", o_err, 1'b0);

    // vsync rising on the same cycle as a line end: restart only.
    line(8, 1'b0, fw, wb, cb, bb, la);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    line(8, 1'b0, fw, wb, cb, bb, la);
    chk("vs_line_end_wen", fw, 4'b0001);
    @(negedge clk);
    chk("vs_line_end_sel", o_conv_ln_sel, 2'd1);

    // Reset in the middle of an active line.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("midline_reset_outs", {o_mem_wen, o_mem_ren, o_mem_addr, o_conv_ln_sel, o_conv_en,
                               o_bypass, o_border, o_err, o_vs, o_hs, o_de}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    gap = '0;
    repeat (4) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      gap |= o_mem_wen;
    end
    chk("no_wen_after_reset", gap, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    frame_start(1'b0);
    line(8, 1'b0, fw, wb, cb, bb, la);
    chk("resume_wen", fw, 4'b0001);
    chk("resume_wen_bits", wb, 32'h000000FF);

    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
